// File: rtl/inst_queue.sv
// Dual-lane instruction FIFO between fetch and decode: up to two pushes and two pops per cycle,
// strictly in order, with a registered count driving both in_ready and out_valid.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int EXCP_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [1:0]        in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc0,
    input  logic [31:0]       in_pc1,
    input  logic [31:0]       in_inst0,
    input  logic [31:0]       in_inst1,
    input  logic [1:0]        in_pred_taken,
    input  logic [31:0]       in_pred_target0,
    input  logic [31:0]       in_pred_target1,
    input  logic [1:0]        in_excp,
    input  logic [EXCP_W-1:0] in_ecode0,
    input  logic [EXCP_W-1:0] in_ecode1,
    output logic [1:0]        out_valid,
    output logic [31:0]       out_pc0,
    output logic [31:0]       out_pc1,
    output logic [31:0]       out_inst0,
    output logic [31:0]       out_inst1,
    output logic [1:0]        out_pred_taken,
    output logic [31:0]       out_pred_target0,
    output logic [31:0]       out_pred_target1,
    output logic [1:0]        out_excp,
    output logic [EXCP_W-1:0] out_ecode0,
    output logic [EXCP_W-1:0] out_ecode1,
    input  logic [1:0]        out_accept
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic              pred_taken;
        logic [31:0]       pred_target;
        logic              excp;
        logic [EXCP_W-1:0] ecode;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [1:0]      push_n, pop_n;
    entry_t          in_e0, in_e1, hd0, hd1;

    assign in_e0 = '{pc: in_pc0, inst: in_inst0, pred_taken: in_pred_taken[0],
                     pred_target: in_pred_target0, excp: in_excp[0], ecode: in_ecode0};
    assign in_e1 = '{pc: in_pc1, inst: in_inst1, pred_taken: in_pred_taken[1],
                     pred_target: in_pred_target1, excp: in_excp[1], ecode: in_ecode1};

    // Ready looks only at the registered count; a same-cycle pop gives no credit.
    assign in_ready     = (count <= CW'(DEPTH - 2));
    assign out_valid[0] = (count != '0);
    assign out_valid[1] = (count >= CW'(2));

    always_comb begin
        push_n = 2'd0;
        if (in_ready) begin
            if (in_valid == 2'b01)      push_n = 2'd1;
            else if (in_valid == 2'b11) push_n = 2'd2;
        end
        pop_n = 2'd0;
        if (out_accept[0] && out_valid[0])
            pop_n = (out_accept[1] && out_valid[1]) ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_n != 2'd0) mem[tail]          <= in_e0;
            if (push_n == 2'd2) mem[tail + AW'(1)] <= in_e1;
            tail  <= tail + AW'(push_n);
            head  <= head + AW'(pop_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    assign hd0 = mem[head];
    assign hd1 = mem[head + AW'(1)];

    assign out_pc0          = hd0.pc;
    assign out_pc1          = hd1.pc;
    assign out_inst0        = hd0.inst;
    assign out_inst1        = hd1.inst;
    assign out_pred_taken   = {hd1.pred_taken, hd0.pred_taken};
    assign out_pred_target0 = hd0.pred_target;
    assign out_pred_target1 = hd1.pred_target;
    assign out_excp         = {hd1.excp, hd0.excp};
    assign out_ecode0       = hd0.ecode;
    assign out_ecode1       = hd1.ecode;
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8): latency, full threshold, wrap, flush, passthrough, async reset.
module tb_inst_queue;
    localparam int DEPTH  = 8;
    localparam int EXCP_W = 6;

    logic              clk = 1'b0;
    logic              resetn, flush;
    logic [1:0]        in_valid, in_pred_taken, in_excp, out_accept;
    logic              in_ready;
    logic [31:0]       in_pc0, in_pc1, in_inst0, in_inst1, in_pred_target0, in_pred_target1;
    logic [EXCP_W-1:0] in_ecode0, in_ecode1;
    logic [1:0]        out_valid, out_pred_taken, out_excp;
    logic [31:0]       out_pc0, out_pc1, out_inst0, out_inst1, out_pred_target0, out_pred_target1;
    logic [EXCP_W-1:0] out_ecode0, out_ecode1;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    inst_queue #(.DEPTH(DEPTH), .EXCP_W(EXCP_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_pred_taken(in_pred_taken), .in_pred_target0(in_pred_target0),
        .in_pred_target1(in_pred_target1), .in_excp(in_excp), .in_ecode0(in_ecode0),
        .in_ecode1(in_ecode1), .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_inst0(out_inst0), .out_inst1(out_inst1), .out_pred_taken(out_pred_taken),
        .out_pred_target0(out_pred_target0), .out_pred_target1(out_pred_target1),
        .out_excp(out_excp), .out_ecode0(out_ecode0), .out_ecode1(out_ecode1),
        .out_accept(out_accept)
    );

    always #5 clk = ~clk;

    always @(posedge clk) assert (in_valid != 2'b10);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 2'b00; out_accept = 2'b00; flush = 1'b0;
        in_pred_taken = 2'b00; in_excp = 2'b00;
        in_pred_target0 = '0; in_pred_target1 = '0; in_ecode0 = '0; in_ecode1 = '0;
    endtask

    // inst is derived from pc so one scoreboard of pcs covers both fields
    task automatic set_push(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        in_valid = v;
        in_pc0 = p0; in_inst0 = p0 ^ 32'h5a5a_0000;
        in_pc1 = p1; in_inst1 = p1 ^ 32'h5a5a_0000;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        set_push(v, p0, p1);
        if (in_ready) begin
            exp_q.push_back(p0);
            if (v == 2'b11) exp_q.push_back(p1);
        end
        step();
        idle();
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            chk({tag, " v0"}, 32'(out_valid[0]), 32'd1);
            chk({tag, " pc0"}, out_pc0, exp_q[0]);
            chk({tag, " inst0"}, out_inst0, exp_q[0] ^ 32'h5a5a_0000);
            if (exp_q.size() >= 2) begin
                chk({tag, " pc1"}, out_pc1, exp_q[1]);
                out_accept = 2'b11;
                void'(exp_q.pop_front());
            end else begin
                out_accept = 2'b01;
            end
            void'(exp_q.pop_front());
            step();
            idle();
            guard++;
        end
        chk({tag, " empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        set_push(2'b00, '0, '0);
        #2;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_pc0", out_pc0, 32'd0);
        chk("rst out_inst1", out_inst1, 32'd0);
        #20 resetn = 1'b1;
        step();

        // first push: not visible in the accepting cycle, visible the next
        set_push(2'b01, 32'h1c00_0000, 32'h0);
        in_inst0 = 32'h0280_0421;
        chk("lat same-cycle", 32'(out_valid), 32'd0);
        step();
        idle();
        chk("lat out_valid", 32'(out_valid), 32'h1);
        chk("lat out_pc0", out_pc0, 32'h1c00_0000);
        chk("lat out_inst0", out_inst0, 32'h0280_0421);
        out_accept = 2'b01;
        step();
        idle();
        chk("pop1 empty", 32'(out_valid), 32'd0);

        // accept while empty must not disturb the count
        out_accept = 2'b11;
        step();
        idle();
        push(2'b01, 32'h0000_0050, 32'h0);
        chk("empty-accept valid", 32'(out_valid), 32'h1);
        drain("post-empty");

        // fill two per cycle: 2 free entries still admit a pair, 0 free stall
        for (int k = 0; k < 4; k++) begin
            chk("fill ready", 32'(in_ready), 32'd1);
            push(2'b11, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k));
        end
        chk("full ready", 32'(in_ready), 32'd0);
        chk("full valid", 32'(out_valid), 32'h3);
        push(2'b11, 32'h0bad_0000, 32'h0bad_0004);
        out_accept = 2'b01;
        step();
        idle();
        void'(exp_q.pop_front());
        chk("count7 ready", 32'(in_ready), 32'd0);
        drain("fill");

        // steady state at DEPTH-2 with push 2 + pop 2, across pointer wrap
        for (int k = 0; k < 3; k++) push(2'b11, 32'h200 + 32'(8 * k), 32'h204 + 32'(8 * k));
        for (int k = 0; k < 3; k++) begin
            chk("steady ready", 32'(in_ready), 32'd1);
            chk("steady pc0", out_pc0, exp_q[0]);
            chk("steady pc1", out_pc1, exp_q[1]);
            set_push(2'b11, 32'h300 + 32'(8 * k), 32'h304 + 32'(8 * k));
            out_accept = 2'b11;
            exp_q.push_back(in_pc0);
            exp_q.push_back(in_pc1);
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            step();
            idle();
        end
        chk("steady valid", 32'(out_valid), 32'h3);
        drain("steady");

        // flush beats a same-cycle push and pop
        push(2'b11, 32'h400, 32'h404);
        push(2'b11, 32'h408, 32'h40c);
        push(2'b01, 32'h410, 32'h0);
        flush = 1'b1;
        set_push(2'b11, 32'h0dead_000, 32'h0dead_004);
        out_accept = 2'b11;
        step();
        idle();
        exp_q.delete();
        chk("flush valid", 32'(out_valid), 32'd0);
        chk("flush ready", 32'(in_ready), 32'd1);
        push(2'b01, 32'h500, 32'h0);
        drain("post-flush");

        // lane 1 side-band passes through unchanged; accept 10 is ignored
        set_push(2'b11, 32'h600, 32'h604);
        in_pred_taken = 2'b10; in_pred_target1 = 32'h1c00_0100;
        in_excp = 2'b10; in_ecode1 = 6'h08;
        exp_q.push_back(32'h600);
        exp_q.push_back(32'h604);
        step();
        idle();
        chk("pt valid", 32'(out_valid), 32'h3);
        chk("pt taken", 32'(out_pred_taken), 32'h2);
        chk("pt target1", out_pred_target1, 32'h1c00_0100);
        chk("pt excp", 32'(out_excp), 32'h2);
        chk("pt ecode1", 32'(out_ecode1), 32'h08);
        chk("pt ecode0", 32'(out_ecode0), 32'h00);
        out_accept = 2'b10;
        step();
        idle();
        chk("acc10 ignored", out_pc0, 32'h600);
        drain("pt");

        // asynchronous reset mid-stream with four entries queued
        push(2'b11, 32'h700, 32'h704);
        push(2'b11, 32'h708, 32'h70c);
        chk("pre-rst valid", 32'(out_valid), 32'h3);
        #2 resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst valid", 32'(out_valid), 32'd0);
        chk("arst ready", 32'(in_ready), 32'd1);
        chk("arst pc0", out_pc0, 32'd0);
        chk("arst inst1", out_inst1, 32'd0);
        chk("arst target1", out_pred_target1, 32'd0);
        #4 resetn = 1'b1;
        step();
        chk("post-rst valid", 32'(out_valid), 32'd0);
        push(2'b01, 32'h800, 32'h0);
        drain("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
